// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   state_e  : responder FSM states (IDLE / WAIT / LOAD)
//   phase_e  : loader byte phase (LO = expecting low byte, HI = expecting high byte)
//   INST_*   : default geometry of the instruction memory
//   LAT_CNT_W: width of the latency down-counter (LATENCY is 1..4)
package inst_mem_pkg;

    localparam int INST_ADDR_W = 10;
    localparam int INST_DATA_W = 16;
    localparam int INST_DEPTH  = 1024;
    localparam int LAT_CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } state_e;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

endpackage

// File: rtl/inst_mem_responder_ram.sv
// Single-port synchronous instruction RAM, DEPTH x DATA_W.
//   clk   : clock
//   en    : enable; no read or write happens when low
//   we    : write enable (qualified by en)
//   addr  : word address for both read and write
//   wdata : write data
//   rdata : registered read data (value of mem[addr] at the last enabled edge)
// The array has no reset; read data is not reset either.
module inst_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Memory-side responder for the icache instruction-fetch interface, plus a
// byte-serial program loader that fills the instruction RAM.
//   clk, async_rst_n : clock, asynchronous active-low reset
//   clk_en           : global enable; all state and RAM writes freeze when low
//   req, address     : fetch request and word address
//   data_out, valid  : response word and its one-enabled-cycle strobe
//   busy             : high whenever a request would not be accepted (not IDLE)
//   load_start/end   : enter/leave load mode
//   load_byte_valid,
//   load_byte        : program bytes, low byte first
//   load_count       : words written in the current/last load (saturates at DEPTH)
//   load_overflow    : sticky, set when the write pointer wraps
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W  = INST_ADDR_W,
    parameter int DATA_W  = INST_DATA_W,
    parameter int DEPTH   = INST_DEPTH,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_end,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow
);

    localparam logic [LAT_CNT_W-1:0] CNT_INIT  = LAT_CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0]    PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]      COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    state_e                 state_q, state_d;
    phase_e                 phase_q, phase_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [7:0]             hold_q, hold_d;
    logic [ADDR_W:0]        load_count_q, load_count_d;
    logic                   load_overflow_q, load_overflow_d;

    logic                   ram_we;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic [DATA_W-1:0]      ram_rdata;
    logic                   do_wr;
    logic [7:0]             wr_hi;

    inst_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (clk_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        data_out_d      = data_out_q;
        valid_d         = 1'b0;
        ptr_d           = ptr_q;
        hold_d          = hold_q;
        load_count_d    = load_count_q;
        load_overflow_d = load_overflow_q;
        ram_we          = 1'b0;
        ram_addr        = addr_q;
        ram_wdata       = '0;
        do_wr           = 1'b0;
        wr_hi           = 8'h00;

        case (state_q)
            IDLE: begin
                // Read the incoming address on the accepting edge so that
                // LATENCY=1 already has RAM data at the next edge.
                ram_addr = address;
                if (load_start) begin
                    state_d         = LOAD;
                    ptr_d           = '0;
                    phase_d         = PH_LO;
                    load_count_d    = '0;
                    load_overflow_d = 1'b0;
                end else if (req) begin
                    addr_d  = address;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                ram_addr = addr_q;
                if (cnt_q == '0) begin
                    data_out_d = ram_rdata;
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            LOAD: begin
                ram_addr = ptr_q;
                if (load_start) begin
                    ptr_d           = '0;
                    phase_d         = PH_LO;
                    load_count_d    = '0;
                    load_overflow_d = 1'b0;
                end else begin
                    if (load_byte_valid) begin
                        if (phase_q == PH_LO) begin
                            hold_d  = load_byte;
                            phase_d = PH_HI;
                        end else begin
                            do_wr   = 1'b1;
                            wr_hi   = load_byte;
                            phase_d = PH_LO;
                        end
                    end
                    // The byte of this cycle is handled first; a low byte
                    // still pending on exit is flushed with a zero high byte.
                    // At most one write can result from either path.
                    if (load_end) begin
                        state_d = IDLE;
                        if (phase_d == PH_HI) begin
                            do_wr   = 1'b1;
                            wr_hi   = 8'h00;
                            phase_d = PH_LO;
                        end
                    end
                    if (do_wr) begin
                        ram_we    = 1'b1;
                        ram_wdata = DATA_W'({wr_hi, hold_d});
                        ptr_d     = ptr_q + 1'b1;
                        if (ptr_q == PTR_LAST) begin
                            load_overflow_d = 1'b1;
                        end
                        if (load_count_q != COUNT_MAX) begin
                            load_count_d = load_count_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q         <= IDLE;
            phase_q         <= PH_LO;
            cnt_q           <= '0;
            addr_q          <= '0;
            data_out_q      <= '0;
            valid_q         <= 1'b0;
            ptr_q           <= '0;
            hold_q          <= '0;
            load_count_q    <= '0;
            load_overflow_q <= 1'b0;
        end else if (clk_en) begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            data_out_q      <= data_out_d;
            valid_q         <= valid_d;
            ptr_q           <= ptr_d;
            hold_q          <= hold_d;
            load_count_q    <= load_count_d;
            load_overflow_q <= load_overflow_d;
        end
    end

    assign data_out      = data_out_q;
    assign valid         = valid_q;
    assign busy          = (state_q != IDLE);
    assign load_count    = load_count_q;
    assign load_overflow = load_overflow_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder (LATENCY = 2).
// Fetch expectations come from a bench-side picture of what was loaded
// (model_mem) and are queued in exp_q when a request is driven, then popped
// when valid is seen.
module tb_inst_mem_responder;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          async_rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          req = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          busy;
    logic          load_start = 1'b0;
    logic          load_byte_valid = 1'b0;
    logic [7:0]    load_byte = 8'h00;
    logic          load_end = 1'b0;
    logic [AW:0]   load_count;
    logic          load_overflow;

    logic [DW-1:0] model_mem [1024];
    logic [DW-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;

    inst_mem_responder #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .DEPTH   (1024),
        .LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .async_rst_n     (async_rst_n),
        .clk_en          (clk_en),
        .req             (req),
        .address         (address),
        .data_out        (data_out),
        .valid           (valid),
        .busy            (busy),
        .load_start      (load_start),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_end        (load_end),
        .load_count      (load_count),
        .load_overflow   (load_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic do_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_end);
        load_byte_valid = 1'b1;
        load_byte       = b;
        load_end        = with_end;
        tick();
        load_byte_valid = 1'b0;
        load_end        = 1'b0;
    endtask

    function automatic logic [15:0] word_of(input int i);
        return 16'((i * 37) + 16'h1234);
    endfunction

    // Fetch one word; checks busy, latency, data and the one-cycle strobe.
    task automatic fetch(input logic [AW-1:0] a, input string nm);
        int n;
        logic [DW-1:0] e;
        exp_q.push_back(model_mem[a]);
        req     = 1'b1;
        address = a;
        tick();
        req     = 1'b0;
        address = ~a;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_accept got=%b want=1", nm, busy);
        end
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL %s valid_timeout got=%b want=1", nm, valid);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) begin
                bad++;
                $display("FAIL %s data got=%h want=%h", nm, data_out, e);
            end
            total++;
            if (n !== LAT) begin
                bad++;
                $display("FAIL %s latency got=%0d want=%0d", nm, n, LAT);
            end
        end
        tick();
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL %s valid_one_cycle got=%b want=0", nm, valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        async_rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", data_out); end
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (load_count !== 11'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", load_count); end
        total++;
        if (load_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", load_overflow); end
        async_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_fetch();
        do_start();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b want=1", busy); end
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        do_end();
        model_mem[0] = 16'h1234;
        model_mem[1] = 16'h5678;
        total++;
        if (load_count !== 11'd2) begin bad++; $display("FAIL load_count got=%0d want=2", load_count); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
        fetch(10'd0, "fetch0");
        fetch(10'd1, "fetch1");
    endtask

    task automatic test_odd_load();
        do_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        do_end();
        model_mem[0] = 16'hBBAA;
        model_mem[1] = 16'h00CC;
        total++;
        if (load_count !== 11'd2) begin bad++; $display("FAIL odd_count got=%0d want=2", load_count); end
        fetch(10'd0, "odd0");
        fetch(10'd1, "odd1");
        // load_end together with a byte: byte first, then exit
        do_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        model_mem[0] = 16'h2211;
        total++;
        if (load_count !== 11'd1) begin bad++; $display("FAIL end_hi_count got=%0d want=1", load_count); end
        do_start();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        model_mem[0] = 16'h4433;
        model_mem[1] = 16'h0055;
        total++;
        if (load_count !== 11'd2) begin bad++; $display("FAIL end_lo_count got=%0d want=2", load_count); end
        fetch(10'd0, "endbyte0");
        fetch(10'd1, "endbyte1");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a_list [4];
        logic [DW-1:0] e;
        a_list = '{10'd2, 10'd0, 10'd3, 10'd1};
        do_start();
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 16'hA000 + 16'(i * 16'h0111);
            send_byte(model_mem[i][7:0], 1'b0);
            send_byte(model_mem[i][15:8], 1'b0);
        end
        do_end();
        total++;
        if (load_count !== 11'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", load_count); end
        req     = 1'b1;
        address = a_list[0];
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model_mem[address]);
            tick();
            address = 10'h3FF;
            total++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                bad++; $display("FAIL b2b_wait1_%0d busy=%b valid=%b want busy=1 valid=0", i, busy, valid);
            end
            tick();
            total++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                bad++; $display("FAIL b2b_wait2_%0d busy=%b valid=%b want busy=1 valid=0", i, busy, valid);
            end
            if (i < 3) address = a_list[i+1];
            else req = 1'b0;
            tick();
            total++;
            if (valid !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL b2b_valid_%0d valid=%b busy=%b want valid=1 busy=0", i, valid, busy);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (data_out !== e) begin bad++; $display("FAIL b2b_data_%0d got=%h want=%h", i, data_out, e); end
            end
        end
        tick();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_drain valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_clk_en();
        logic [DW-1:0] e;
        exp_q.push_back(model_mem[2]);
        req     = 1'b1;
        address = 10'd2;
        tick();
        req     = 1'b0;
        tick();
        clk_en = 1'b0;
        repeat (5) tick();
        total++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL clken_frozen valid=%b busy=%b want 0 1", valid, busy);
        end
        clk_en = 1'b1;
        tick();
        total++;
        if (valid !== 1'b1) begin
            bad++; $display("FAIL clken_valid got=%b want=1", valid);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) begin bad++; $display("FAIL clken_data got=%h want=%h", data_out, e); end
        end
        clk_en = 1'b0;
        repeat (2) tick();
        total++;
        if (valid !== 1'b1) begin bad++; $display("FAIL clken_valid_hold got=%b want=1", valid); end
        clk_en = 1'b1;
        tick();
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL clken_valid_drop got=%b want=0", valid); end
        // frozen load: byte presented while disabled must be ignored
        do_start();
        send_byte(8'h99, 1'b0);
        clk_en          = 1'b0;
        load_byte_valid = 1'b1;
        load_byte       = 8'h88;
        repeat (3) tick();
        load_byte_valid = 1'b0;
        clk_en          = 1'b1;
        total++;
        if (load_count !== 11'd0) begin bad++; $display("FAIL clken_load_count got=%0d want=0", load_count); end
        send_byte(8'h77, 1'b0);
        do_end();
        model_mem[0] = 16'h7799;
        total++;
        if (load_count !== 11'd1) begin bad++; $display("FAIL clken_load_count2 got=%0d want=1", load_count); end
        fetch(10'd0, "clken_mem0");
        fetch(10'd1, "clken_mem1");
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < 1025; i++) begin
            logic [15:0] w;
            w = word_of(i);
            send_byte(w[7:0], 1'b0);
            send_byte(w[15:8], 1'b0);
        end
        do_end();
        for (int i = 1; i < 1024; i++) model_mem[i] = word_of(i);
        model_mem[0] = word_of(1024);
        total++;
        if (load_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", load_overflow); end
        total++;
        if (load_count !== 11'd1024) begin bad++; $display("FAIL ovf_count got=%0d want=1024", load_count); end
        fetch(10'd0, "ovf_mem0");
        fetch(10'd1023, "ovf_mem1023");
        fetch(10'd5, "ovf_mem5");
        do_start();
        total++;
        if (load_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", load_overflow); end
        total++;
        if (load_count !== 11'd0) begin bad++; $display("FAIL ovf_count_clear got=%0d want=0", load_count); end
        do_end();
    endtask

    task automatic test_reset_mid();
        logic saw;
        // abort a fetch in WAIT
        req     = 1'b1;
        address = 10'd5;
        tick();
        req = 1'b0;
        #3 async_rst_n = 1'b0;
        #1;
        total++;
        if (data_out !== 16'h0000 || valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_wait data=%h valid=%b busy=%b want 0000 0 0", data_out, valid, busy);
        end
        tick();
        async_rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (valid === 1'b1) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0) begin bad++; $display("FAIL rst_wait_no_valid got=%b want=0", saw); end
        // abort a load with one full word written and one byte pending
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        total++;
        if (load_count !== 11'd1) begin bad++; $display("FAIL rst_load_pre got=%0d want=1", load_count); end
        #3 async_rst_n = 1'b0;
        #1;
        total++;
        if (load_count !== 11'd0 || busy !== 1'b0 || load_overflow !== 1'b0) begin
            bad++; $display("FAIL rst_load count=%0d busy=%b ovf=%b want 0 0 0", load_count, busy, load_overflow);
        end
        tick();
        async_rst_n = 1'b1;
        tick();
        model_mem[0] = 16'h0201;
        fetch(10'd0, "rst_mem0");
        fetch(10'd1, "rst_mem1");
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_odd_load();
        test_back_to_back();
        test_clk_en();
        test_overflow();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the instruction-fetch interface driven by the icache (mreq / address_out / from_mem).
- Accepts a fetch request with a 10-bit word address and returns a 16-bit instruction after a fixed, parameterised latency, with a one-cycle valid strobe.
- Also contains a byte-serial program loader that fills the instruction RAM from a host/debug port. The CPU top is held idle while loading.

Parameters:
- ADDR_W, 10, instruction word address width.
- DATA_W, 16, instruction width; fixed at 2 bytes for the loader.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.
- LATENCY, 2, enabled cycles from request acceptance to valid; legal range 1..4.

Ports:
- clk  in  1  system clock
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; all state frozen when 0
- req  in  1  fetch request (icache mreq)
- address  in  ADDR_W  fetch word address
- data_out  out  DATA_W  instruction word returned
- valid  out  1  one-cycle strobe: data_out holds the response
- busy  out  1  request will not be accepted this cycle
- load_start  in  1  enter load mode, pointer cleared to 0
- load_byte_valid  in  1  load_byte qualifier
- load_byte  in  8  program byte, low byte first
- load_end  in  1  leave load mode
- load_count  out  ADDR_W+1  words written in last/current load
- load_overflow  out  1  sticky: pointer wrapped during load

Behaviour:
- Reset (async assert, sync release): state=IDLE; data_out=0, valid=0, busy=0, load_count=0, load_overflow=0, pointer=0, byte phase=LO. RAM contents are not reset. Reset mid-fetch or mid-load aborts the operation with no response; any partial word is lost.
- clk_en=0: no state, counter, output or RAM write changes. A valid that is high stays high until the next enabled cycle.
- States: IDLE, WAIT, LOAD.
- IDLE:
  - load_start=1 has priority over req and moves to LOAD (pointer=0, phase=LO, load_count=0, load_overflow=0).
  - Otherwise req=1 latches address, loads counter=LATENCY-1 and moves to WAIT.
- WAIT:
  - busy=1. Counter decrements each enabled cycle.
  - When counter=0, a synchronous RAM read completes: data_out=mem[latched address], valid=1 for exactly one enabled cycle, return to IDLE.
  - valid is high exactly LATENCY enabled cycles after the accepting edge.
  - req and load_start are ignored in WAIT. Address changes after acceptance do not affect the response.
- Throughput: one response per LATENCY+1 enabled cycles. A req held high in the valid cycle is accepted on the following edge.
- data_out holds its last value between responses.
- LOAD:
  - busy=1; req ignored.
  - load_byte_valid in phase LO stores the byte in a holding register and sets phase=HI.
  - load_byte_valid in phase HI writes {load_byte, held} to mem[pointer], then pointer+1, load_count+1, phase=LO.
  - When pointer=DEPTH-1, the increment wraps to 0 and sets load_overflow=1 (sticky until next load_start). load_count saturates at DEPTH.
  - load_end returns to IDLE. If phase=HI, the pending low byte is written with high byte 0x00 and counted. load_end and load_byte_valid in the same cycle: the byte is processed first, then the exit.
  - load_start while in LOAD restarts: pointer=0, count cleared, any partial byte discarded.
- Read-during-write cannot occur, since fetches and loads are mutually exclusive.
- busy=0 only in IDLE.

Decomposition:
- Package inst_mem_pkg holds:
  - state enum (IDLE, WAIT, LOAD);
  - the byte-phase enum;
  - constants INST_ADDR_W=10, INST_DATA_W=16, INST_DEPTH=1024.
- Sub-module inst_ram: single-port synchronous RAM (DEPTH x DATA_W), registered read, write-enable, no reset on the array. The responder FSM, latency counter and loader live in the top.

Test Plan:
- Load bytes 0x34,0x12,0x78,0x56, then load_end; fetch address 0 -> data_out=0x1234 with valid exactly 2 cycles after acceptance; fetch address 1 -> 0x5678; load_count=2.
- Three bytes 0xAA,0xBB,0xCC, then load_end -> mem[0]=0xBBAA, mem[1]=0x00CC, load_count=2.
- req held high continuously with LATENCY=2 -> valid pulses every 3 cycles; busy=1 in the 2 cycles after each acceptance; address changed mid-WAIT has no effect.
- clk_en low for 5 cycles during WAIT -> valid appears 5 cycles late, still a single enabled-cycle pulse; clk_en low during LOAD -> no RAM writes.
- Write 1025 words -> load_overflow=1, load_count=1024, mem[0] holds word 1024; the next load_start clears the flag.
- async_rst_n asserted mid-WAIT and mid-LOAD -> all outputs 0 immediately, no valid afterwards; previously loaded RAM words still read correctly after release.
